output_port_driver: RTL
=======================

# output_port_driver

Drives CPU output-register writes onto external pins as a strobed parallel transfer with guaranteed setup, strobe-width and hold times. An optional four-phase acknowledge is supported, with timeout. It sits between the CPU's output-port write path and the chip pins. It is the outbound counterpart of the input synchronizer chain: any external `port_ack_i` reaches this block only after passing through an input synchronizer instance, and this block does not resynchronize it.

## Interface
- `DATA_WIDTH`, default 4: width of the output data bus.
- `SETUP_CYCLES`, default 1: cycles data is stable before the strobe rises. Must be ≥1.
- `STROBE_CYCLES`, default 4: minimum strobe-high cycles. Must be ≥1.
- `HOLD_CYCLES`, default 1: cycles data is held after the strobe falls. Must be ≥1.
- `ACK_ENABLE`, default 0: 1 enables the four-phase acknowledge on `port_ack_i`.
- `TIMEOUT_CYCLES`, default 16: maximum acknowledge-wait cycles. Must be ≥1. Used only when `ACK_ENABLE` = 1.
- `clk_i` input 1: single clock; all logic on the rising edge.
- `reset_i` input 1: synchronous, active-high reset.
- `wr_valid_i` input 1: CPU write request.
- `wr_data_i` input DATA_WIDTH: write data.
- `wr_ready_o` output 1: block can accept a write.
- `port_data_o` output DATA_WIDTH: registered pin data.
- `port_strobe_o` output 1: registered pin strobe, active-high.
- `port_ack_i` input 1: synchronized device acknowledge. Ignored when `ACK_ENABLE` = 0.
- `busy_o` output 1: a transfer is in progress.
- `timeout_o` output 1: sticky flag; the last transfer timed out.

## Operation
- **States:** IDLE, SETUP, STROBE, HOLD, ACK_RELEASE. A down-counter (cnt) sized for the largest parameter times each state.
- **Reset:** `reset_i` high at a clock edge forces the following, regardless of state (including mid-transfer):
  - state = IDLE
  - `port_data_o` = 0, `port_strobe_o` = 0, `timeout_o` = 0, cnt = 0
- **`wr_ready_o`:** equals (state == IDLE) && !`reset_i`.
- **`busy_o`:** equals state != IDLE.
- **IDLE:**
  - On `wr_valid_i` && `wr_ready_o`: `port_data_o` <= `wr_data_i`, `timeout_o` <= 0, go to SETUP with cnt = SETUP_CYCLES-1.
  - Otherwise `port_data_o` retains its last value. Pins are never returned to 0 except by reset.
- **SETUP:** Strobe low. When cnt == 0, go to STROBE with cnt = STROBE_CYCLES-1; `port_strobe_o` <= 1 on that edge. Otherwise decrement cnt.
- **STROBE:** Strobe high.
  - `ACK_ENABLE` = 0: when cnt == 0, `port_strobe_o` <= 0 and go to HOLD with cnt = HOLD_CYCLES-1.
  - `ACK_ENABLE` = 1: leave only when cnt == 0 and `port_ack_i` == 1. The timeout counter (tcnt) starts at TIMEOUT_CYCLES on entry to STROBE and decrements each cycle once cnt == 0 and ack is absent. When tcnt reaches 0: `port_strobe_o` <= 0, `timeout_o` <= 1, go to IDLE directly (no HOLD).
- **HOLD:** Strobe low, data held. When cnt == 0:
  - `ACK_ENABLE` = 0: go to IDLE.
  - `ACK_ENABLE` = 1: go to ACK_RELEASE with tcnt reloaded to TIMEOUT_CYCLES.
- **ACK_RELEASE:** Wait for `port_ack_i` == 0, then go to IDLE. If tcnt expires first: `timeout_o` <= 1, go to IDLE.
- **Writes while busy:** `wr_valid_i` while not ready is ignored, not queued. The CPU must hold valid until it sees ready.
- **Data stability:** `port_data_o` never changes while `busy_o` = 1.

## Timing
- Acceptance happens at edge E0, when valid && ready are sampled high.
- `port_data_o` takes the new value in the cycle after E0 (cycle 1).
- Strobe is high in cycles 1+S through S+P, where S = SETUP_CYCLES and P = STROBE_CYCLES; P is extended by the ack wait when enabled.
- HOLD occupies cycles S+P+1 through S+P+H, where H = HOLD_CYCLES.
- `wr_ready_o` returns high in cycle S+P+H+1. Back-to-back writes are therefore spaced S+P+H+1 cycles (7 with defaults).
- All pin outputs are registered. There is no combinational path from `wr_*` or `port_ack_i` to the pins.
- `wr_ready_o` is combinational from the state register and `reset_i`.

## Test plan
- **Reset then single write, defaults:**
  - Stimulus: deassert reset; one-cycle valid with data 4'hA at edge 0.
  - Required: ready=1 in cycle 0; `port_data_o` = A from cycle 1; strobe high exactly cycles 2–5; busy cycles 1–6; ready=1 in cycle 7; outputs 0 before the write.
- **Back-to-back writes, defaults:**
  - Stimulus: hold valid continuously with data 3 then C.
  - Required: data 3 accepted at edge 0; C accepted at edge 7; `port_data_o` changes 3→C in cycle 8; exactly two strobe pulses, each 4 cycles.
- **Write while busy:**
  - Stimulus: pulse valid with data 5 during cycle 3 of a transfer carrying 9.
  - Required: 5 never appears on `port_data_o`; only one strobe pulse occurs.
- **ACK_ENABLE=1 handshake:**
  - Stimulus: raise ack 6 cycles after the strobe rises; drop ack 3 cycles after the strobe falls.
  - Required: strobe high for 7 cycles; ready returns the cycle after ack is seen low; `timeout_o` = 0.
- **ACK_ENABLE=1 timeout:**
  - Stimulus: TIMEOUT_CYCLES=8; ack held at 0.
  - Required: strobe falls after 4+8 cycles high; `timeout_o` = 1 and stays 1 until the next accepted write clears it.
- **Reset mid-transfer:**
  - Stimulus: assert reset for one cycle during the strobe.
  - Required: at the next edge, strobe, data, busy and timeout are all 0; ready=1 once reset is low; a new write then behaves as in the first scenario.

Source files
------------

// File: rtl/output_port_driver.sv
// Strobed parallel output port: registers CPU writes onto pins with fixed
// setup/strobe/hold timing and an optional four-phase acknowledge with timeout.
module output_port_driver #(
  parameter int unsigned DATA_WIDTH     = 4,
  parameter int unsigned SETUP_CYCLES   = 1,
  parameter int unsigned STROBE_CYCLES  = 4,
  parameter int unsigned HOLD_CYCLES    = 1,
  parameter int unsigned ACK_ENABLE     = 0,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  wr_valid_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  wr_ready_o,
  output logic [DATA_WIDTH-1:0] port_data_o,
  output logic                  port_strobe_o,
  input  logic                  port_ack_i,
  output logic                  busy_o,
  output logic                  timeout_o
);

  localparam int unsigned SP_MAX  = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int unsigned CNT_MAX = (SP_MAX > HOLD_CYCLES) ? SP_MAX : HOLD_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned TCNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam bit          ACK_ON  = (ACK_ENABLE != 0);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    ACK_RELEASE
  } state_t;

  state_t                state_q, state_n;
  logic [CNT_W-1:0]      cnt_q, cnt_n;
  logic [TCNT_W-1:0]     tcnt_q, tcnt_n;
  logic [DATA_WIDTH-1:0] data_n;
  logic                  strobe_n;
  logic                  timeout_n;

  assign wr_ready_o = (state_q == IDLE) && !reset_i;
  assign busy_o     = (state_q != IDLE);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      tcnt_q        <= '0;
      port_data_o   <= '0;
      port_strobe_o <= 1'b0;
      timeout_o     <= 1'b0;
    end else begin
      state_q       <= state_n;
      cnt_q         <= cnt_n;
      tcnt_q        <= tcnt_n;
      port_data_o   <= data_n;
      port_strobe_o <= strobe_n;
      timeout_o     <= timeout_n;
    end
  end

  // Pin outputs are computed here as next-state values so they stay registered.
  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    tcnt_n    = tcnt_q;
    data_n    = port_data_o;
    strobe_n  = port_strobe_o;
    timeout_n = timeout_o;
    case (state_q)
      IDLE: begin
        if (wr_valid_i) begin
          data_n    = wr_data_i;
          timeout_n = 1'b0;
          cnt_n     = CNT_W'(SETUP_CYCLES - 1);
          state_n   = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          strobe_n = 1'b1;
          cnt_n    = CNT_W'(STROBE_CYCLES - 1);
          tcnt_n   = TCNT_W'(TIMEOUT_CYCLES);
          state_n  = STROBE;
        end else begin
          cnt_n = cnt_q - CNT_W'(1);
        end
      end
      STROBE: begin
        if (cnt_q != '0) begin
          cnt_n = cnt_q - CNT_W'(1);
        end else if (!ACK_ON || port_ack_i) begin
          strobe_n = 1'b0;
          cnt_n    = CNT_W'(HOLD_CYCLES - 1);
          state_n  = HOLD;
        end else if (tcnt_q == '0) begin
          // Timed-out transfers skip HOLD and return straight to IDLE.
          strobe_n  = 1'b0;
          timeout_n = 1'b1;
          state_n   = IDLE;
        end else begin
          tcnt_n = tcnt_q - TCNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt_q != '0) begin
          cnt_n = cnt_q - CNT_W'(1);
        end else if (ACK_ON) begin
          tcnt_n  = TCNT_W'(TIMEOUT_CYCLES);
          state_n = ACK_RELEASE;
        end else begin
          state_n = IDLE;
        end
      end
      ACK_RELEASE: begin
        if (!port_ack_i) begin
          state_n = IDLE;
        end else if (tcnt_q == '0) begin
          timeout_n = 1'b1;
          state_n   = IDLE;
        end else begin
          tcnt_n = tcnt_q - TCNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
